// File: rtl/add8u_pkg.sv
// rtl/add8u_pkg.sv - shared types and widths for the add8u error monitor
package add8u_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/add8u_err_monitor_if.sv
// rtl/add8u_err_monitor_if.sv - sample handshake bus into the add8u error monitor
interface add8u_err_monitor_if;
  import add8u_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic [RES_W-1:0] in_o;

  modport master (output in_valid, output in_a, output in_b, output in_o, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, input in_o, output in_ready);

endinterface

// File: rtl/add8u_absdiff.sv
// rtl/add8u_absdiff.sv - combinational |x - y| on adder-result-width operands
module add8u_absdiff
  import add8u_pkg::*;
(
  input  logic [RES_W-1:0] i_x,
  input  logic [RES_W-1:0] i_y,
  output logic [RES_W-1:0] o_d
);

  logic [RES_W:0] w_diff;
  logic [RES_W:0] w_neg;

  // One extra bit acts as the sign; the magnitude always fits back in RES_W bits.
  assign w_diff = {1'b0, i_x} - {1'b0, i_y};
  assign w_neg  = -w_diff;
  assign o_d    = w_diff[RES_W] ? w_neg[RES_W-1:0] : w_diff[RES_W-1:0];

endmodule

// File: rtl/add8u_err_monitor.sv
// rtl/add8u_err_monitor.sv - error statistics (EP/MAE/WCE) for 8-bit approximate adders; ERR_SQ_EN adds sum of err^2
module add8u_err_monitor
  import add8u_pkg::*;
#(
  parameter int CNT_W = 17,
  parameter int ACC_W = 26
`ifdef ERR_SQ_EN
  ,
  parameter int SQ_W  = 36
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    n_samples,
  add8u_err_monitor_if.slave  s_in,
  output logic                stats_valid,
  output logic [CNT_W-1:0]    samp_cnt,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [ACC_W-1:0]    abs_sum,
  output logic [RES_W-1:0]    wce
`ifdef ERR_SQ_EN
  ,
  output logic [SQ_W-1:0]     sq_sum
`endif
);

  state_t           r_state;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_acc_cnt;
  logic             r_in_ready;
  logic             r_stats_valid;

  logic             r_s1_valid;
  logic [RES_W-1:0] r_s1_exact;
  logic [RES_W-1:0] r_s1_o;
  logic             r_s2_valid;
  logic [RES_W-1:0] r_s2_d;

  logic [CNT_W-1:0] r_samp_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [ACC_W-1:0] r_abs_sum;
  logic [RES_W-1:0] r_wce;

  logic             w_accept;
  logic             w_clear;
  logic [CNT_W-1:0] w_acc_next;
  logic [RES_W-1:0] w_d;
  logic [CNT_W:0]   w_samp_sum;
  logic [CNT_W:0]   w_err_sum;
  logic [ACC_W:0]   w_abs_sum;

  assign w_accept   = s_in.in_valid & r_in_ready;
  assign w_clear    = start & ((r_state == IDLE) | (r_state == DONE));
  assign w_acc_next = r_acc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_n           <= '0;
      r_acc_cnt     <= '0;
      r_in_ready    <= 1'b0;
      r_stats_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_n       <= n_samples;
            r_acc_cnt <= '0;
            if (n_samples == '0) begin
              r_state       <= DONE;
              r_in_ready    <= 1'b0;
              r_stats_valid <= 1'b1;
            end else begin
              r_state       <= RUN;
              r_in_ready    <= 1'b1;
              r_stats_valid <= 1'b0;
            end
          end
        end
        RUN: begin
          if (w_accept) begin
            r_acc_cnt <= w_acc_next;
            if (w_acc_next == r_n) begin
              r_state    <= DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // S2 retires on this edge, so an empty S1 means stats are final next cycle.
          if (!r_s1_valid) begin
            r_state       <= DONE;
            r_stats_valid <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  add8u_absdiff u_absdiff (
    .i_x (r_s1_exact),
    .i_y (r_s1_o),
    .o_d (w_d)
  );

  assign w_samp_sum = {1'b0, r_samp_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_err_sum  = {1'b0, r_err_cnt} + {{CNT_W{1'b0}}, (r_s2_d != '0)};
  assign w_abs_sum  = {1'b0, r_abs_sum} + {{(ACC_W+1-RES_W){1'b0}}, r_s2_d};

`ifdef ERR_SQ_EN
  logic [SQ_W-1:0]    r_sq_sum;
  logic [2*RES_W-1:0] w_sq;
  logic [SQ_W:0]      w_sq_sum;

  assign w_sq     = {{RES_W{1'b0}}, r_s2_d} * {{RES_W{1'b0}}, r_s2_d};
  assign w_sq_sum = {1'b0, r_sq_sum} + {{(SQ_W+1-2*RES_W){1'b0}}, w_sq};
  assign sq_sum   = r_sq_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_exact <= '0;
      r_s1_o     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_d     <= '0;
      r_samp_cnt <= '0;
      r_err_cnt  <= '0;
      r_abs_sum  <= '0;
      r_wce      <= '0;
`ifdef ERR_SQ_EN
      r_sq_sum   <= '0;
`endif
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_exact <= {1'b0, s_in.in_a} + {1'b0, s_in.in_b};
        r_s1_o     <= s_in.in_o;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_d <= w_d;
      end

      if (w_clear) begin
        r_samp_cnt <= '0;
        r_err_cnt  <= '0;
        r_abs_sum  <= '0;
        r_wce      <= '0;
`ifdef ERR_SQ_EN
        r_sq_sum   <= '0;
`endif
      end else if (r_s2_valid) begin
        // Saturate at all-ones rather than wrap.
        r_samp_cnt <= w_samp_sum[CNT_W] ? '1 : w_samp_sum[CNT_W-1:0];
        r_err_cnt  <= w_err_sum[CNT_W]  ? '1 : w_err_sum[CNT_W-1:0];
        r_abs_sum  <= w_abs_sum[ACC_W]  ? '1 : w_abs_sum[ACC_W-1:0];
        if (r_s2_d > r_wce) begin
          r_wce <= r_s2_d;
        end
`ifdef ERR_SQ_EN
        r_sq_sum   <= w_sq_sum[SQ_W] ? '1 : w_sq_sum[SQ_W-1:0];
`endif
      end
    end
  end

  assign s_in.in_ready = r_in_ready;
  assign stats_valid   = r_stats_valid;
  assign samp_cnt      = r_samp_cnt;
  assign err_cnt       = r_err_cnt;
  assign abs_sum       = r_abs_sum;
  assign wce           = r_wce;

endmodule
